rv32_run_ctrl: RTL

- Run controller that sequences the single-cycle RV32 core: streams a program image into instruction memory, then holds the core in reset, releases it, and supervises execution.
- Stops the core on ECALL/EBREAK, on a cycle budget, or on an external abort.
- Sits between the bench/host loader and the rv32_processor top level.
- Drives the core's active-low reset and the instruction memory write port.

---
 rtl/rv32_run_pkg.sv | 29 ++
 rtl/rv32_imem_loader.sv | 65 ++++++
 rtl/rv32_run_ctrl.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/rv32_run_pkg.sv
// Shared types and constants for the RV32 run controller.
// Contents: controller state enum, halt-cause enum, the SYSTEM opcodes that
// stop the core, and a helper that recognises them.
package rv32_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_HOLD = 3'd2,
    ST_RUN  = 3'd3,
    ST_HALT = 3'd4
  } run_state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'd0,
    CAUSE_SYSTEM  = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_ABORT   = 2'd3
  } halt_cause_t;

  localparam logic [31:0] INSTR_ECALL  = 32'h00000073;
  localparam logic [31:0] INSTR_EBREAK = 32'h00100073;

  // ECALL or EBREAK ends a program run
  function automatic logic is_stop_instr(input logic [31:0] instr);
    return (instr == INSTR_ECALL) || (instr == INSTR_EBREAK);
  endfunction

endpackage

// File: rtl/rv32_imem_loader.sv
// Instruction-memory loader: valid/ready intake of a program image and
// generation of the instruction-memory write port.
// Ports:
//   clk, reset            clock, async active-high reset
//   begin_load            pulse: rewind pointer and open the intake
//   load_valid/data/last  loader word stream
//   load_ready            registered: intake open for a word this cycle
//   imem_we/waddr/wdata   write port, combinational from the handshake
//   words_loaded          words accepted since begin_load (registered)
//   done                  combinational: this handshake completes the image
module rv32_imem_loader
  import rv32_run_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              begin_load,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words_loaded,
  output logic              done
);

  localparam int unsigned PTR_W = ADDR_W + 1;

  logic [PTR_W-1:0] ptr_q;
  logic             ready_q;
  logic             hs;
  logic             at_end;

  // Pointer bound guards the write port even if the intake were left open
  assign hs     = load_valid & ready_q & (ptr_q < PTR_W'(IMEM_DEPTH));
  assign at_end = (ptr_q == PTR_W'(IMEM_DEPTH - 1));
  assign done   = hs & (load_last | at_end);

  // Write port zeroed when idle so the memory bus is quiet between writes
  assign imem_we    = hs;
  assign imem_waddr = hs ? ptr_q[ADDR_W-1:0] : '0;
  assign imem_wdata = hs ? load_data : '0;

  assign load_ready   = ready_q;
  assign words_loaded = ptr_q;

  // Intake opens on begin_load and closes right after the completing word
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q   <= '0;
      ready_q <= 1'b0;
    end else if (begin_load) begin
      ptr_q   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (hs)   ptr_q   <= ptr_q + PTR_W'(1);
      if (done) ready_q <= 1'b0;
    end
  end

endmodule

// File: rtl/rv32_run_ctrl.sv
// Run controller for the single-cycle RV32 core: loads a program image into
// instruction memory, holds the core in reset, releases it, and supervises
// execution until ECALL/EBREAK, cycle-budget timeout or external abort.
// Ports:
//   clk, reset          clock, async active-high controller reset
//   start               pulse: begin LOAD from IDLE or HALT
//   abort               level: force HALT from RUN
//   load_*              loader word stream and ready
//   imem_*              instruction memory write port (combinational)
//   core_resetn         active-low reset to the core (high only in RUN)
//   core_instr          instruction the core is executing
//   busy, halted        status flags
//   halt_cause          0 none, 1 ecall/ebreak, 2 timeout, 3 abort
//   cycle_count         RUN cycles elapsed (saturating)
//   words_loaded        words written in the last LOAD
module rv32_run_ctrl
  import rv32_run_pkg::*;
#(
  parameter int unsigned IMEM_DEPTH = 256,
  parameter int unsigned ADDR_W     = 8,
  parameter int unsigned MAX_CYCLES = 1024,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned RST_HOLD   = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
  output logic              load_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              core_resetn,
  input  logic [31:0]       core_instr,
  output logic              busy,
  output logic              halted,
  output logic [1:0]        halt_cause,
  output logic [CYC_W-1:0]  cycle_count,
  output logic [ADDR_W:0]   words_loaded
);

  localparam int unsigned HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  run_state_t        state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [CYC_W-1:0]  cyc_q, cyc_d;
  halt_cause_t       cause_q, cause_d;
  logic              resetn_q, busy_q, halted_q;
  logic              begin_load;
  logic              load_done;

  rv32_imem_loader #(
    .IMEM_DEPTH (IMEM_DEPTH),
    .ADDR_W     (ADDR_W)
  ) u_loader (
    .clk          (clk),
    .reset        (reset),
    .begin_load   (begin_load),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_last    (load_last),
    .load_ready   (load_ready),
    .imem_we      (imem_we),
    .imem_waddr   (imem_waddr),
    .imem_wdata   (imem_wdata),
    .words_loaded (words_loaded),
    .done         (load_done)
  );

  // Next-state and next-counter logic
  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    cyc_d      = cyc_q;
    cause_d    = cause_q;
    begin_load = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          begin_load = 1'b1;
          state_d    = ST_LOAD;
          cyc_d      = '0;
          cause_d    = CAUSE_NONE;
        end
      end
      ST_LOAD: begin
        if (load_done) begin
          state_d = ST_HOLD;
          hold_d  = HOLD_W'(RST_HOLD - 1);
        end
      end
      ST_HOLD: begin
        if (hold_q == '0) state_d = ST_RUN;
        else              hold_d  = hold_q - HOLD_W'(1);
      end
      ST_RUN: begin
        // The halting cycle itself is counted
        if (cyc_q != '1) cyc_d = cyc_q + CYC_W'(1);
        if (abort) begin
          state_d = ST_HALT;
          cause_d = CAUSE_ABORT;
        end else if (is_stop_instr(core_instr)) begin
          state_d = ST_HALT;
          cause_d = CAUSE_SYSTEM;
        end else if (cyc_q == CYC_W'(MAX_CYCLES - 1)) begin
          state_d = ST_HALT;
          cause_d = CAUSE_TIMEOUT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counters and status flags; flags derive from the next state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hold_q   <= '0;
      cyc_q    <= '0;
      cause_q  <= CAUSE_NONE;
      resetn_q <= 1'b0;
      busy_q   <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hold_q   <= hold_d;
      cyc_q    <= cyc_d;
      cause_q  <= cause_d;
      resetn_q <= (state_d == ST_RUN);
      busy_q   <= (state_d == ST_LOAD) || (state_d == ST_HOLD) || (state_d == ST_RUN);
      halted_q <= (state_d == ST_HALT);
    end
  end

  assign core_resetn = resetn_q;
  assign busy        = busy_q;
  assign halted      = halted_q;
  assign halt_cause  = cause_q;
  assign cycle_count = cyc_q;

endmodule
